qdr_dly_sequencer: RTL and testbench

QDR_DLY_SEQUENCER -- requirements
Module: qdr_dly_sequencer

---
 rtl/qdr_dly_sequencer.sv | 173 +++++++++++++++++
 tb/tb_qdr_dly_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/qdr_dly_sequencer.sv
// QDR IDELAY/IODELAY tap sequencer.
// Accepts one tap-adjust command at a time and turns it into a train of
// one-cycle enable pulses on either the input or the output delay bank.
// A change of direction is applied first and allowed to settle before the
// first pulse. Consecutive pulses are spaced STEP_GAP cycles apart.
module qdr_dly_sequencer #(
    parameter int N_I      = 36,
    parameter int N_O      = 37,
    parameter int STEP_GAP = 4,
    parameter int SETTLE   = 8
) (
    input  logic           dly_clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_sel_o,
    input  logic           cmd_all,
    input  logic [5:0]     cmd_index,
    input  logic           cmd_inc,
    input  logic [4:0]     cmd_steps,
    output logic [N_I-1:0] dly_en_i,
    output logic [N_O-1:0] dly_en_o,
    output logic           dly_inc_dec,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [4:0]     steps_done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        GAP   = 3'd3,
        FIN   = 3'd4
    } state_t;

    // Countdown loads: SETUP lasts SETTLE cycles, GAP lasts STEP_GAP-1 cycles.
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);
    localparam logic [3:0] GAP_LD    = 4'(STEP_GAP - 2);
    localparam logic [6:0] N_I_LIM   = 7'(N_I);
    localparam logic [6:0] N_O_LIM   = 7'(N_O);

    state_t     state;
    logic       sel_r;
    logic       all_r;
    logic [5:0] idx_r;
    logic [4:0] left_r;
    logic [3:0] cnt_r;

    logic           cmd_bad;
    logic           p_sel;
    logic           p_all;
    logic [5:0]     p_idx;
    logic [N_I-1:0] en_i_nxt;
    logic [N_O-1:0] en_o_nxt;

    function automatic logic [N_I-1:0] mask_i(input logic all, input logic [5:0] idx);
        if (all) return '1;
        return N_I'(1) << idx;
    endfunction

    function automatic logic [N_O-1:0] mask_o(input logic all, input logic [5:0] idx);
        if (all) return '1;
        return N_O'(1) << idx;
    endfunction

    // Ready is a pure decode of IDLE so it drops the moment reset is raised.
    assign cmd_ready = (state == IDLE) && !rst;

    // An individual tap index beyond the selected bank is rejected.
    assign cmd_bad = !cmd_all &&
                     (cmd_sel_o ? ({1'b0, cmd_index} >= N_O_LIM)
                                : ({1'b0, cmd_index} >= N_I_LIM));

    // The first pulse can be issued straight from IDLE, so the pulse pattern
    // comes from the live command fields there and from the latched copy later.
    assign p_sel    = (state == IDLE) ? cmd_sel_o : sel_r;
    assign p_all    = (state == IDLE) ? cmd_all   : all_r;
    assign p_idx    = (state == IDLE) ? cmd_index : idx_r;
    assign en_i_nxt = p_sel ? '0 : mask_i(p_all, p_idx);
    assign en_o_nxt = p_sel ? mask_o(p_all, p_idx) : '0;

    // Command sequencing FSM; every output is registered with the state.
    always_ff @(posedge dly_clk) begin
        if (rst) begin
            state       <= IDLE;
            sel_r       <= 1'b0;
            all_r       <= 1'b0;
            idx_r       <= '0;
            left_r      <= '0;
            cnt_r       <= '0;
            dly_en_i    <= '0;
            dly_en_o    <= '0;
            dly_inc_dec <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            steps_done  <= '0;
        end else begin
            dly_en_i <= '0;
            dly_en_o <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        sel_r      <= cmd_sel_o;
                        all_r      <= cmd_all;
                        idx_r      <= cmd_index;
                        steps_done <= '0;
                        busy       <= 1'b1;
                        if (cmd_bad || cmd_steps == 5'd0) begin
                            state  <= FIN;
                            left_r <= '0;
                            done   <= 1'b1;
                            err    <= cmd_bad;
                        end else if (cmd_inc != dly_inc_dec) begin
                            state       <= SETUP;
                            dly_inc_dec <= cmd_inc;
                            cnt_r       <= SETTLE_LD;
                            left_r      <= cmd_steps;
                        end else begin
                            state      <= PULSE;
                            dly_en_i   <= en_i_nxt;
                            dly_en_o   <= en_o_nxt;
                            steps_done <= 5'd1;
                            left_r     <= cmd_steps - 5'd1;
                        end
                    end
                end
                SETUP: begin
                    if (cnt_r == 4'd0) begin
                        state      <= PULSE;
                        dly_en_i   <= en_i_nxt;
                        dly_en_o   <= en_o_nxt;
                        steps_done <= steps_done + 5'd1;
                        left_r     <= left_r - 5'd1;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                PULSE: begin
                    state <= GAP;
                    cnt_r <= GAP_LD;
                end
                GAP: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else if (left_r == 5'd0) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end else begin
                        state      <= PULSE;
                        dly_en_i   <= en_i_nxt;
                        dly_en_o   <= en_o_nxt;
                        steps_done <= steps_done + 5'd1;
                        left_r     <= left_r - 5'd1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qdr_dly_sequencer.sv
// Scoreboard bench for qdr_dly_sequencer: the driver predicts a timeline of
// pulses and done for every accepted command; the monitor checks what the
// DUT actually emits against that queue.
module tb_qdr_dly_sequencer;

    localparam int N_I      = 36;
    localparam int N_O      = 37;
    localparam int STEP_GAP = 4;
    localparam int SETTLE   = 8;

    logic           dly_clk = 1'b0;
    logic           rst = 1'b1;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic           cmd_sel_o = 1'b0;
    logic           cmd_all = 1'b0;
    logic [5:0]     cmd_index = '0;
    logic           cmd_inc = 1'b0;
    logic [4:0]     cmd_steps = '0;
    logic [N_I-1:0] dly_en_i;
    logic [N_O-1:0] dly_en_o;
    logic           dly_inc_dec;
    logic           busy;
    logic           done;
    logic           err;
    logic [4:0]     steps_done;

    qdr_dly_sequencer #(.N_I(N_I), .N_O(N_O), .STEP_GAP(STEP_GAP), .SETTLE(SETTLE)) dut (
        .dly_clk(dly_clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_sel_o(cmd_sel_o), .cmd_all(cmd_all), .cmd_index(cmd_index),
        .cmd_inc(cmd_inc), .cmd_steps(cmd_steps), .dly_en_i(dly_en_i),
        .dly_en_o(dly_en_o), .dly_inc_dec(dly_inc_dec), .busy(busy),
        .done(done), .err(err), .steps_done(steps_done)
    );

    always #5 dly_clk = ~dly_clk;

    int cyc = 0;
    always @(posedge dly_clk) cyc <= cyc + 1;

    typedef struct {
        int             at;
        bit             is_done;
        bit             bank;
        logic [N_O-1:0] mask;
        bit             err;
        int             sd;
        bit             dir;
    } ev_t;

    ev_t q[$];
    int  total = 0;
    int  bad = 0;

    // Reference state: tap direction, earliest next acceptance, last count.
    bit mdir = 1'b0;
    int next_ready = 0;
    int last_sd = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse or done the DUT presents must match the queue head.
    always @(negedge dly_clk) begin
        ev_t e;
        if (dly_en_i != '0 && dly_en_o != '0) chk("both_banks", 1, 0);
        if (err && !done) chk("err_without_done", 1, 0);
        if (dly_en_i != '0 || dly_en_o != '0) begin
            if (q.size() == 0 || q[0].is_done) begin
                chk("unexpected_pulse", {27'd0, dly_en_o}, 0);
            end else begin
                e = q.pop_front();
                chk("pulse_cycle", cyc, e.at);
                chk("pulse_bank", dly_en_o != '0, e.bank);
                chk("pulse_mask", dly_en_o | N_O'(dly_en_i), e.mask);
                chk("pulse_dir", dly_inc_dec, e.dir);
            end
        end
        if (done) begin
            if (q.size() == 0 || !q[0].is_done) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("done_cycle", cyc, e.at);
                chk("done_err", err, e.err);
                chk("done_steps", steps_done, e.sd);
                chk("done_dir", dly_inc_dec, e.dir);
                chk("done_busy", busy, 1);
            end
        end
    end

    // Issue one command and predict its timeline. keep < 0 predicts the full
    // command; keep >= 0 predicts only that many pulses (reset will abort it).
    task automatic send(input bit sel, input bit all, input int idx, input bit inc,
                        input int steps, input int keep);
        int v, t, b, first, lim;
        bit illegal;
        ev_t e;
        @(negedge dly_clk);
        cmd_sel_o = sel; cmd_all = all; cmd_index = 6'(idx);
        cmd_inc = inc; cmd_steps = 5'(steps); cmd_valid = 1'b1;
        v = cyc;
        b = 0;
        while (!cmd_ready) begin
            @(negedge dly_clk);
            b++;
            if (b > 500) begin
                chk("accept_timeout", 0, 1);
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        end
        t = cyc;
        chk("accept_cycle", t, (v > next_ready) ? v : next_ready);
        chk("steps_hold", steps_done, last_sd);
        lim = sel ? N_O : N_I;
        illegal = !all && (idx >= lim);
        e.bank = sel; e.err = 1'b0; e.is_done = 1'b0;
        e.mask = '0;
        if (all) begin
            for (int k = 0; k < lim; k++) e.mask[k] = 1'b1;
        end else if (!illegal) begin
            e.mask[idx] = 1'b1;
        end
        if (illegal || steps == 0) begin
            e.is_done = 1'b1; e.at = t + 1; e.err = illegal; e.sd = 0; e.dir = mdir;
            q.push_back(e);
            next_ready = t + 2;
            last_sd = 0;
        end else begin
            if (inc != mdir) begin
                first = t + 1 + SETTLE;
                mdir = inc;
            end else begin
                first = t + 1;
            end
            e.dir = mdir;
            for (int k = 0; k < steps; k++) begin
                if (keep < 0 || k < keep) begin
                    e.at = first + k * STEP_GAP;
                    q.push_back(e);
                end
            end
            if (keep < 0) begin
                e.is_done = 1'b1; e.at = first + steps * STEP_GAP; e.err = 1'b0; e.sd = steps;
                q.push_back(e);
            end
            next_ready = first + steps * STEP_GAP + 1;
            last_sd = steps;
        end
        @(posedge dly_clk);
        #1;
        cmd_valid = 1'b0;
        cmd_sel_o = 1'($urandom); cmd_all = 1'($urandom); cmd_index = 6'($urandom);
        cmd_inc = 1'($urandom); cmd_steps = 5'($urandom);
    endtask

    task automatic drain(input string nm);
        int b;
        b = 0;
        while (q.size() != 0 && b < 400) begin
            @(negedge dly_clk);
            b++;
        end
        chk(nm, q.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge dly_clk);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_steps", steps_done, 0);
        chk("rst_en_i", dly_en_i, 0);
        chk("rst_en_o", dly_en_o, 0);
        chk("rst_dir", dly_inc_dec, 0);
        rst = 1'b0;
        next_ready = cyc;
        #1;
        chk("ready_after_rst", cmd_ready, 1);

        // Directed: direction change, full bank, illegal indices, zero steps.
        send(0, 0, 5, 1, 3, -1);
        send(1, 1, 0, 1, 2, -1);
        send(1, 0, 37, 0, 3, -1);
        send(0, 0, 36, 1, 2, -1);
        send(1, 0, 36, 1, 1, -1);
        send(0, 0, 3, 0, 0, -1);
        send(0, 1, 0, 0, 2, -1);
        send(0, 0, 35, 0, 1, -1);
        drain("drain_directed");

        // Abort after the second of five pulses.
        send(0, 0, 7, 1, 5, 2);
        drain("drain_before_abort");
        rst = 1'b1;
        @(negedge dly_clk);
        chk("abort_en_i", dly_en_i, 0);
        chk("abort_dir", dly_inc_dec, 0);
        chk("abort_steps", steps_done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", cmd_ready, 0);
        rst = 1'b0;
        mdir = 1'b0;
        last_sd = 0;
        next_ready = cyc;
        #1;
        chk("abort_ready_release", cmd_ready, 1);
        repeat (30) @(negedge dly_clk);
        chk("abort_no_done_busy", busy, 0);

        // Randomized commands, including out-of-range indices and zero steps.
        for (int n = 0; n < 40; n++) begin
            send(1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 40),
                 1'($urandom), $urandom_range(0, 5), -1);
        end
        drain("drain_random");
        repeat (5) @(negedge dly_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
